// File: rtl/uart_cmd_frame_wrapper.sv
// uart_cmd_frame_wrapper: multi-byte command/response framer around the UART transceiver.
// Ports:
//   clk, rst_n   : system clock, asynchronous active-low reset
//   RX, TX       : serial pins (TX idles high)
//   clr_cmd_rdy  : consumer acknowledge, clears cmd_rdy
//   trmt, resp   : one-cycle send request and the response word sampled with it
//   cmd, cmd_rdy : last complete command (MSB byte first) and its valid flag
//   frame_to     : one-cycle pulse when a partial frame is dropped by the inter-byte timeout
//   tx_busy      : response serialisation in progress
//   tx_done      : whole response sent, held until the next accepted trmt
// UART: 8N1 transceiver, BAUD_DIV clocks per bit; rx_rdy holds until clr_rx_rdy or a new
//   start bit, tx_done clears when trmt is sampled and sets when the stop bit completes.

module UART #(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       trmt,
    input  logic       clr_rx_rdy,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       rx_rdy,
    output logic       tx_done,
    output logic [7:0] rx_data
);
    localparam int BW = ($clog2(BAUD_DIV) < 1) ? 1 : $clog2(BAUD_DIV);

    logic [1:0]    rx_sync_q;
    logic          rx_busy_q;
    logic [BW-1:0] rx_baud_q;
    logic [3:0]    rx_bit_q;
    logic [7:0]    rx_shift_q;
    logic          rx_rdy_q;

    logic          tx_busy_q;
    logic [BW-1:0] tx_baud_q;
    logic [3:0]    tx_bit_q;
    logic [9:0]    tx_shift_q;
    logic          tx_done_q;

    // Receiver: a start edge arms a half-bit delay so every later sample lands mid-bit.
    // Sample 0 is the start bit, 1..8 the data bits LSB first, 9 the stop bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync_q  <= 2'b11;
            rx_busy_q  <= 1'b0;
            rx_baud_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_rdy_q   <= 1'b0;
        end else begin
            rx_sync_q <= {rx_sync_q[0], RX};
            if (clr_rx_rdy)
                rx_rdy_q <= 1'b0;
            if (!rx_busy_q) begin
                if (!rx_sync_q[1]) begin
                    rx_busy_q <= 1'b1;
                    rx_baud_q <= BW'(BAUD_DIV / 2);
                    rx_bit_q  <= '0;
                    rx_rdy_q  <= 1'b0;
                end
            end else if (rx_baud_q != '0) begin
                rx_baud_q <= rx_baud_q - 1'b1;
            end else begin
                rx_baud_q <= BW'(BAUD_DIV - 1);
                rx_bit_q  <= rx_bit_q + 1'b1;
                if (rx_bit_q >= 4'd1 && rx_bit_q <= 4'd8)
                    rx_shift_q <= {rx_sync_q[1], rx_shift_q[7:1]};
                if (rx_bit_q == 4'd9) begin
                    rx_busy_q <= 1'b0;
                    rx_rdy_q  <= 1'b1;
                end
            end
        end
    end

    // Transmitter: {stop, data, start} shifted out LSB first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_busy_q  <= 1'b0;
            tx_baud_q  <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '1;
            tx_done_q  <= 1'b0;
        end else if (trmt && !tx_busy_q) begin
            tx_busy_q  <= 1'b1;
            tx_baud_q  <= BW'(BAUD_DIV - 1);
            tx_bit_q   <= '0;
            tx_shift_q <= {1'b1, tx_data, 1'b0};
            tx_done_q  <= 1'b0;
        end else if (tx_busy_q) begin
            if (tx_baud_q != '0) begin
                tx_baud_q <= tx_baud_q - 1'b1;
            end else begin
                tx_baud_q  <= BW'(BAUD_DIV - 1);
                tx_bit_q   <= tx_bit_q + 1'b1;
                tx_shift_q <= {1'b1, tx_shift_q[9:1]};
                if (tx_bit_q == 4'd9) begin
                    tx_busy_q <= 1'b0;
                    tx_done_q <= 1'b1;
                end
            end
        end
    end

    assign TX      = tx_shift_q[0];
    assign rx_rdy  = rx_rdy_q;
    assign rx_data = rx_shift_q;
    assign tx_done = tx_done_q;
endmodule

module uart_cmd_frame_wrapper #(
    parameter int CMD_BYTES    = 2,
    parameter int RESP_BYTES   = 1,
    parameter int TIMEOUT_CLKS = 1000000,
    parameter int BAUD_DIV     = 434
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    RX,
    input  logic                    clr_cmd_rdy,
    input  logic                    trmt,
    input  logic [8*RESP_BYTES-1:0] resp,
    output logic                    TX,
    output logic [8*CMD_BYTES-1:0]  cmd,
    output logic                    cmd_rdy,
    output logic                    frame_to,
    output logic                    tx_busy,
    output logic                    tx_done
);
    localparam int CW = 8 * CMD_BYTES;
    localparam int RW = 8 * RESP_BYTES;

    logic       u_rx_rdy, u_clr_rx_rdy, u_trmt, u_tx_done;
    logic [7:0] u_rx_data, u_tx_data;

    UART #(.BAUD_DIV(BAUD_DIV)) u_uart (
        .clk       (clk),
        .rst_n     (rst_n),
        .RX        (RX),
        .trmt      (u_trmt),
        .clr_rx_rdy(u_clr_rx_rdy),
        .tx_data   (u_tx_data),
        .TX        (TX),
        .rx_rdy    (u_rx_rdy),
        .tx_done   (u_tx_done),
        .rx_data   (u_rx_data)
    );

    typedef enum logic {IDLE, ASSEMBLE} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_WAIT} tx_state_t;

    rx_state_t     rx_state_q, rx_state_d;
    logic [3:0]    rx_cnt_q, rx_cnt_d;
    logic [CW-1:0] asm_q, asm_d, cmd_q, cmd_d, shifted;
    logic          cmd_rdy_q, cmd_rdy_d, frame_to_q, frame_to_d;
    logic [31:0]   to_cnt_q, to_cnt_d;
    logic          last_byte, to_hit, frame_start;

    // Shift form rather than a concatenation so CMD_BYTES=1 needs no special case;
    // stale bytes from an abandoned frame are pushed out by a full new frame.
    assign shifted   = (asm_q << 8) | CW'(u_rx_data);
    assign last_byte = u_rx_rdy && rx_cnt_q == 4'(CMD_BYTES - 1);
    assign to_hit    = rx_state_q == ASSEMBLE && !u_rx_rdy && TIMEOUT_CLKS != 0 &&
                       to_cnt_q == 32'(TIMEOUT_CLKS - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rx_state_q <= IDLE;
        else
            rx_state_q <= rx_state_d;
    end

    always_comb begin
        rx_state_d = (last_byte || to_hit) ? IDLE : u_rx_rdy ? ASSEMBLE : rx_state_q;
    end

    // The UART byte is consumed the cycle it appears, so rx_rdy acts as a one-cycle strobe.
    always_comb begin
        u_clr_rx_rdy = u_rx_rdy;
        frame_start  = u_rx_rdy && rx_state_q == IDLE;
    end

    always_comb begin
        asm_d      = u_rx_rdy ? shifted : asm_q;
        rx_cnt_d   = (last_byte || to_hit) ? 4'd0 : u_rx_rdy ? rx_cnt_q + 4'd1 : rx_cnt_q;
        cmd_d      = last_byte ? shifted : cmd_q;
        // Completion wins over both the acknowledge and the new-frame clear.
        cmd_rdy_d  = last_byte ? 1'b1 : (frame_start || clr_cmd_rdy) ? 1'b0 : cmd_rdy_q;
        frame_to_d = to_hit;
        to_cnt_d   = (rx_state_q != ASSEMBLE || TIMEOUT_CLKS == 0 || u_rx_rdy || to_hit) ?
                     32'd0 : to_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_cnt_q   <= '0;
            asm_q      <= '0;
            cmd_q      <= '0;
            cmd_rdy_q  <= 1'b0;
            frame_to_q <= 1'b0;
            to_cnt_q   <= '0;
        end else begin
            rx_cnt_q   <= rx_cnt_d;
            asm_q      <= asm_d;
            cmd_q      <= cmd_d;
            cmd_rdy_q  <= cmd_rdy_d;
            frame_to_q <= frame_to_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    tx_state_t     tx_state_q, tx_state_d;
    logic [3:0]    tx_cnt_q, tx_cnt_d;
    logic [RW-1:0] tx_shift_q, tx_shift_d;
    logic          tx_busy_q, tx_busy_d, tx_done_q, tx_done_d;
    logic          accept, byte_sent, last_sent;

    // trmt is only looked at in TX_IDLE, so requests during a response are dropped.
    assign accept    = tx_state_q == TX_IDLE && trmt;
    assign byte_sent = tx_state_q == TX_WAIT && u_tx_done;
    assign last_sent = byte_sent && tx_cnt_q == 4'(RESP_BYTES - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tx_state_q <= TX_IDLE;
        else
            tx_state_q <= tx_state_d;
    end

    always_comb begin
        tx_state_d = accept ? TX_LOAD :
                     tx_state_q == TX_LOAD ? TX_WAIT :
                     byte_sent ? (last_sent ? TX_IDLE : TX_LOAD) : tx_state_q;
    end

    always_comb begin
        u_trmt    = tx_state_q == TX_LOAD;
        u_tx_data = tx_shift_q[RW-1 -: 8];
    end

    always_comb begin
        tx_shift_d = accept ? resp : (byte_sent && !last_sent) ? tx_shift_q << 8 : tx_shift_q;
        tx_cnt_d   = accept ? 4'd0 : (byte_sent && !last_sent) ? tx_cnt_q + 4'd1 : tx_cnt_q;
        tx_busy_d  = accept ? 1'b1 : last_sent ? 1'b0 : tx_busy_q;
        tx_done_d  = accept ? 1'b0 : last_sent ? 1'b1 : tx_done_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_cnt_q   <= '0;
            tx_shift_q <= '0;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            tx_cnt_q   <= tx_cnt_d;
            tx_shift_q <= tx_shift_d;
            tx_busy_q  <= tx_busy_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign cmd      = cmd_q;
    assign cmd_rdy  = cmd_rdy_q;
    assign frame_to = frame_to_q;
    assign tx_busy  = tx_busy_q;
    assign tx_done  = tx_done_q;
endmodule

// File: tb/tb_uart_cmd_frame_wrapper.sv
// tb_uart_cmd_frame_wrapper: directed bench for the command/response framer with queue scoreboards.
module tb_uart_cmd_frame_wrapper;
    localparam int BD = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rx = 3'b111;
    logic [2:0]  clr = 3'b000;
    logic        trmt2 = 1'b0;
    logic [23:0] resp2 = '0;
    logic        tx2, tx4, tx3;
    logic [15:0] cmd2;
    logic [31:0] cmd4;
    logic [23:0] cmd3;
    logic        rdy2, rdy4, rdy3, fto2, fto4, fto3;
    logic        busy2, busy4, busy3, done2, done4, done3;

    uart_cmd_frame_wrapper #(.CMD_BYTES(2), .RESP_BYTES(3), .TIMEOUT_CLKS(500), .BAUD_DIV(BD)) d2 (
        .clk(clk), .rst_n(rst_n), .RX(rx[0]), .clr_cmd_rdy(clr[0]), .trmt(trmt2), .resp(resp2),
        .TX(tx2), .cmd(cmd2), .cmd_rdy(rdy2), .frame_to(fto2), .tx_busy(busy2), .tx_done(done2));
    uart_cmd_frame_wrapper #(.CMD_BYTES(4), .RESP_BYTES(1), .TIMEOUT_CLKS(0), .BAUD_DIV(BD)) d4 (
        .clk(clk), .rst_n(rst_n), .RX(rx[1]), .clr_cmd_rdy(clr[1]), .trmt(1'b0), .resp(8'h00),
        .TX(tx4), .cmd(cmd4), .cmd_rdy(rdy4), .frame_to(fto4), .tx_busy(busy4), .tx_done(done4));
    uart_cmd_frame_wrapper #(.CMD_BYTES(3), .RESP_BYTES(1), .TIMEOUT_CLKS(500), .BAUD_DIV(BD)) d3 (
        .clk(clk), .rst_n(rst_n), .RX(rx[2]), .clr_cmd_rdy(clr[2]), .trmt(1'b0), .resp(8'h00),
        .TX(tx3), .cmd(cmd3), .cmd_rdy(rdy3), .frame_to(fto3), .tx_busy(busy3), .tx_done(done3));

    int errs = 0;
    int checks = 0;
    logic [31:0] cq2[$], cq4[$], cq3[$];
    logic [7:0]  txq[$];
    logic        tx_mon_en = 1'b1;
    logic        p2 = 1'b0, p4 = 1'b0, p3 = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int k, input logic [7:0] b);
        @(negedge clk) rx[k] = 1'b0;
        repeat (BD - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk) rx[k] = b[i];
            repeat (BD - 1) @(negedge clk);
        end
        @(negedge clk) rx[k] = 1'b1;
        repeat (BD - 1) @(negedge clk);
    endtask

    // Command scoreboard: every rising cmd_rdy must match the next expected word.
    always @(negedge clk) begin
        if (rdy2 && !p2) chk("cmd2_frame", 64'(cmd2), cq2.size() != 0 ? 64'(cq2.pop_front()) : '1);
        if (rdy4 && !p4) chk("cmd4_frame", 64'(cmd4), cq4.size() != 0 ? 64'(cq4.pop_front()) : '1);
        if (rdy3 && !p3) chk("cmd3_frame", 64'(cmd3), cq3.size() != 0 ? 64'(cq3.pop_front()) : '1);
        p2 = rdy2;
        p4 = rdy4;
        p3 = rdy3;
    end

    // Response scoreboard: decode d2's TX line and match bytes in order.
    always begin
        logic [7:0] b;
        @(negedge tx2);
        repeat (BD / 2) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            repeat (BD) @(posedge clk);
            b[i] = tx2;
        end
        repeat (BD) @(posedge clk);
        if (tx_mon_en) chk("tx_byte", 64'(b), txq.size() != 0 ? 64'(txq.pop_front()) : '1);
    end

    initial begin
        int n, at, bad, seen;
        repeat (3) @(negedge clk);
        chk("rst_cmd2", 64'(cmd2), 0);
        chk("rst_rdy2", 64'(rdy2), 0);
        chk("rst_fto2", 64'(fto2), 0);
        chk("rst_busy2", 64'(busy2), 0);
        chk("rst_done2", 64'(done2), 0);
        chk("rst_tx2", 64'(tx2), 1);
        chk("rst_cmd4", 64'(cmd4), 0);
        chk("rst_cmd3", 64'(cmd3), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        cq2.push_back(32'hA53C);
        send(0, 8'hA5);
        send(0, 8'h3C);
        repeat (5) @(negedge clk);
        chk("cmd2_rdy", 64'(rdy2), 1);
        chk("cmd2_val", 64'(cmd2), 64'hA53C);
        clr[0] = 1'b1;
        @(negedge clk) clr[0] = 1'b0;
        @(negedge clk);
        chk("cmd2_cleared", 64'(rdy2), 0);
        chk("cmd2_hold", 64'(cmd2), 64'hA53C);

        cq4.push_back(32'h01234567);
        send(1, 8'h01);
        send(1, 8'h23);
        send(1, 8'h45);
        send(1, 8'h67);
        repeat (3) @(negedge clk);
        chk("cmd4_rdy", 64'(rdy4), 1);
        send(1, 8'h89);
        repeat (2) @(negedge clk);
        chk("cmd4_newframe_drop", 64'(rdy4), 0);
        chk("cmd4_hold", 64'(cmd4), 64'h01234567);
        repeat (600) @(negedge clk);
        chk("cmd4_no_timeout", 64'(fto4), 0);
        cq4.push_back(32'h89ABCDEF);
        send(1, 8'hAB);
        send(1, 8'hCD);
        clr[1] = 1'b1;
        send(1, 8'hEF);
        repeat (2) @(negedge clk);
        clr[1] = 1'b0;
        chk("cmd4_val_after_prio", 64'(cmd4), 64'h89ABCDEF);
        chk("cmd4_rdy_cleared_after", 64'(rdy4), 0);

        send(2, 8'h11);
        n = 0;
        at = -1;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (fto3) begin
                n++;
                at = i;
            end
        end
        chk("fto3_pulses", 64'(n), 1);
        chk("fto3_time_window", 64'(at >= 480 && at <= 510), 1);
        chk("cmd3_untouched", 64'(cmd3), 0);
        chk("rdy3_untouched", 64'(rdy3), 0);
        cq3.push_back(32'hAABBCC);
        send(2, 8'hAA);
        send(2, 8'hBB);
        send(2, 8'hCC);
        repeat (3) @(negedge clk);
        chk("cmd3_val", 64'(cmd3), 64'hAABBCC);

        resp2 = 24'hDEAD01;
        txq.push_back(8'hDE);
        txq.push_back(8'hAD);
        txq.push_back(8'h01);
        @(negedge clk) trmt2 = 1'b1;
        @(negedge clk) trmt2 = 1'b0;
        chk("tx_busy_start", 64'(busy2), 1);
        chk("tx_done_start", 64'(done2), 0);
        bad = 0;
        seen = 0;
        for (int i = 0; i < 3000 && seen == 0; i++) begin
            @(negedge clk);
            if (i == 200) begin
                trmt2 = 1'b1;
                resp2 = 24'h555555;
            end
            if (i == 201) trmt2 = 1'b0;
            if (done2) seen = 1;
            else if (!busy2) bad++;
        end
        trmt2 = 1'b0;
        chk("tx_done_seen", 64'(seen), 1);
        chk("tx_busy_throughout", 64'(bad), 0);
        chk("tx_busy_end", 64'(busy2), 0);
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!done2 || busy2) bad++;
        end
        chk("tx_done_held", 64'(bad), 0);
        chk("tx_all_bytes", 64'(txq.size()), 0);
        chk("tx_idle_high", 64'(tx2), 1);

        tx_mon_en = 1'b0;
        resp2 = 24'h0F0F0F;
        @(negedge clk) trmt2 = 1'b1;
        @(negedge clk) trmt2 = 1'b0;
        send(0, 8'h77);
        repeat (40) @(negedge clk);
        chk("mid_busy", 64'(busy2), 1);
        rst_n = 1'b0;
        #1;
        chk("rst2_cmd2", 64'(cmd2), 0);
        chk("rst2_rdy2", 64'(rdy2), 0);
        chk("rst2_fto2", 64'(fto2), 0);
        chk("rst2_busy2", 64'(busy2), 0);
        chk("rst2_done2", 64'(done2), 0);
        chk("rst2_tx2", 64'(tx2), 1);
        chk("rst2_cmd4", 64'(cmd4), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        cq2.push_back(32'h1234);
        send(0, 8'h12);
        send(0, 8'h34);
        repeat (3) @(negedge clk);
        chk("post_rst_cmd2", 64'(cmd2), 64'h1234);
        chk("post_rst_rdy2", 64'(rdy2), 1);

        chk("cq2_drained", 64'(cq2.size()), 0);
        chk("cq4_drained", 64'(cq4.size()), 0);
        chk("cq3_drained", 64'(cq3.size()), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/uart_cmd_frame_wrapper.md
Name: uart_cmd_frame_wrapper

Overview:
- Parametrised command/response framer around the team's existing UART transceiver (`UART`: clk, rst_n, RX, trmt, clr_rx_rdy, tx_data, TX, rx_rdy, tx_done, rx_data).
- RX side: assembles CMD_BYTES serial bytes, MSB byte first, into one registered command word, with an inter-byte timeout that discards partial frames.
- TX side: serialises a RESP_BYTES response word, MSB byte first, from a single trmt request.
- Sits between the serial pins and the command-processing logic, replacing the fixed 2-byte/1-byte wrapper.

Parameters:
- CMD_BYTES, 2: bytes per inbound command; legal 1..8.
- RESP_BYTES, 1: bytes per outbound response; legal 1..8.
- TIMEOUT_CLKS, 1000000: idle clocks allowed between bytes of a partial frame; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- RX  in  1  serial input
- clr_cmd_rdy  in  1  consumer acknowledge; clears cmd_rdy
- trmt  in  1  one-cycle request to send resp
- resp  in  8*RESP_BYTES  response word, sampled when trmt is accepted
- TX  out  1  serial output
- cmd  out  8*CMD_BYTES  last complete command, registered
- cmd_rdy  out  1  complete command available
- frame_to  out  1  one-cycle pulse: partial frame discarded by timeout
- tx_busy  out  1  response serialisation in progress
- tx_done  out  1  whole response sent; held until next accepted trmt

Behaviour:
- Reset is asynchronous, active-low (rst_n); clock is clk. All flops are async-reset.
- Reset values: cmd=0, cmd_rdy=0, frame_to=0, tx_busy=0, tx_done=0, TX idle high (via UART), byte counters=0, RX FSM=IDLE, TX FSM=TX_IDLE.
- RX path:
  - On every cycle with UART rx_rdy=1: pulse clr_rx_rdy the same cycle; shift rx_data into the assembly register (assembly = {assembly[8*CMD_BYTES-9:0], rx_data}); increment rx_cnt.
  - RX FSM states: IDLE (rx_cnt=0) and ASSEMBLE (0<rx_cnt<CMD_BYTES).
  - A byte received in IDLE clears cmd_rdy on that edge, so cmd_rdy drops as a new frame starts.
  - On the final byte (rx_cnt==CMD_BYTES-1 and rx_rdy): cmd <= {assembly, rx_data} and cmd_rdy <= 1 on that edge. Latency is one clock from rx_rdy. Then rx_cnt<=0 and the FSM returns to IDLE.
  - With CMD_BYTES=1, every byte completes a frame.
  - cmd changes only on frame completion; it holds through later partial frames.
  - cmd_rdy set has priority over clr_cmd_rdy in the same cycle. Otherwise clr_cmd_rdy=1 clears it.
  - Timeout: in ASSEMBLE, a counter increments each clock without rx_rdy and resets to 0 on rx_rdy. When it reaches TIMEOUT_CLKS-1: rx_cnt<=0, FSM->IDLE, frame_to pulses 1 cycle. cmd and cmd_rdy are unaffected. The counter is held at 0 in IDLE or when TIMEOUT_CLKS=0.
- TX path:
  - TX FSM states: TX_IDLE, TX_LOAD, TX_WAIT.
  - UART contract: UART tx_done clears on the edge sampling its trmt and sets when the stop bit completes.
  - TX_IDLE with trmt=1: capture resp into the shift register; tx_cnt<=0; tx_busy<=1; tx_done<=0; go to TX_LOAD.
  - TX_LOAD: drive UART tx_data = shift[8*RESP_BYTES-1 -: 8] and pulse UART trmt for one cycle; go to TX_WAIT.
  - TX_WAIT: wait for UART tx_done=1. Then:
    - If tx_cnt==RESP_BYTES-1: tx_busy<=0, tx_done<=1, go to TX_IDLE.
    - Else: shift left 8, increment tx_cnt, go to TX_LOAD.
  - trmt while tx_busy=1 is ignored. resp is not re-sampled mid-response.
- RX and TX paths are independent; simultaneous activity is legal.
- Reset mid-operation aborts both paths immediately: partial frames are lost and TX returns high.

Test Plan:
- CMD_BYTES=2: send 0xA5 then 0x3C -> cmd=16'hA53C, cmd_rdy rises 1 clk after the second rx_rdy; clr_cmd_rdy pulse -> cmd_rdy=0, cmd holds 16'hA53C.
- CMD_BYTES=4: send 0x01,0x23,0x45,0x67 -> cmd=32'h01234567. Then send 0x89 -> cmd_rdy falls on that byte and cmd stays 32'h01234567.
- TIMEOUT_CLKS=500, CMD_BYTES=3: send 0x11, idle 600 clks -> frame_to pulses once at idle clock 500. Then send 0xAA,0xBB,0xCC -> cmd=24'hAABBCC (no stale 0x11).
- RESP_BYTES=3, resp=24'hDEAD01, trmt pulse -> TX shows bytes 0xDE,0xAD,0x01 in order; tx_busy high throughout; tx_done rises once after the third stop bit. Extra trmt mid-send -> ignored.
- Completing byte arrives in the same cycle as clr_cmd_rdy -> cmd_rdy=1.
- Assert rst_n=0 mid-frame and mid-response -> all outputs at reset values. Next full frame, e.g. 0x12,0x34 with CMD_BYTES=2 -> cmd=16'h1234 decoded correctly.
